// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths, load size codes and stage state encoding
package mem_stage_pkg;
    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FWD_BUS_WD   = 39;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } ms_state_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute/write-back/forward/SRAM-response signals around mem_stage
// master: the stage itself (drives allowin, ws bus, forward bus)
// slave : the surrounding pipeline and data SRAM
interface mem_stage_if;
    import mem_stage_pkg::*;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;

    modport master (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );
    modport slave (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: picks byte/half/word out of a 32-bit read word and extends it
// rdata: raw SRAM word, addr: byte offset, ld_op: {unsigned, size[1:0]}, result: extended value
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_op,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    assign b  = rdata[{addr, 3'b000} +: 8];
    assign h  = addr[1] ? rdata[31:16] : rdata[15:0];
    assign sx = ~ld_op[2];
    // size 11 is reserved and falls through to a full word
    assign result = ld_op[1:0] == LD_B ? {{24{b[7] & sx}}, b} :
                    ld_op[1:0] == LD_H ? {{16{h[15] & sx}}, h} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; waits for load data, aligns it, holds result for write-back
// clk/reset: clock and synchronous active-low reset
// io (master): execute handshake in, write-back handshake out, decode forward bus, SRAM response in
module mem_stage
    import mem_stage_pkg::*;
(
    input logic         clk,
    input logic         reset,
    mem_stage_if.master io
);
    ms_state_t                  state;
    logic [ES_TO_MS_BUS_WD-1:0] es_r;
    logic [31:0]                buf_r;
    logic [31:0]                aligned;
    logic [31:0]                final_result;
    logic                       ready_go;
    logic                       held;

    wire [2:0]  ld_op        = es_r[73:71];
    wire        res_from_mem = es_r[70];
    wire        gr_we        = es_r[69];
    wire [4:0]  dest         = es_r[68:64];
    wire [31:0] alu_result   = es_r[63:32];
    wire [31:0] pc           = es_r[31:0];

    assign held     = state != EMPTY;
    assign ready_go = state == READY || (state == WAIT && io.data_sram_data_ok);

    // In WAIT the response goes straight to the aligner; in READY the buffered copy is used
    load_align u_align (
        .rdata  (state == WAIT ? io.data_sram_rdata : buf_r),
        .addr   (alu_result[1:0]),
        .ld_op  (ld_op),
        .result (aligned)
    );

    assign final_result      = res_from_mem ? aligned : alu_result;
    assign io.ms_allowin     = !held || (ready_go && io.ws_allowin);
    assign io.ms_to_ws_valid = ready_go;
    assign io.ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    // dest/result are zeroed when nothing useful is held so the bus reads all-zero when empty
    assign io.ms_fwd_bus     = {held && gr_we,
                                state == WAIT && !io.data_sram_data_ok,
                                held ? dest : 5'd0,
                                ready_go ? final_result : 32'd0};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
            buf_r <= '0;
        end else begin
            if (state == WAIT && io.data_sram_data_ok && !io.ws_allowin)
                buf_r <= io.data_sram_rdata;
            if (io.es_to_ms_valid && io.ms_allowin) begin
                es_r  <= io.es_to_ms_bus;
                state <= io.es_to_ms_bus[70] ? WAIT : READY;
            end else if (ready_go && io.ws_allowin)
                state <= EMPTY;
            else if (state == WAIT && io.data_sram_data_ok)
                state <= READY;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if io();
    mem_stage dut (.clk(clk), .reset(reset), .io(io));

    int n_tests = 0;
    int n_fail  = 0;
    logic [MS_TO_WS_BUS_WD-1:0] exp_q[$];
    logic [MS_TO_WS_BUS_WD-1:0] exp_w;

    function automatic logic [ES_TO_MS_BUS_WD-1:0] mk(logic [2:0] op, logic rfm, logic we,
                                                      logic [4:0] dst, logic [31:0] alu, logic [31:0] pc);
        return {op, rfm, we, dst, alu, pc};
    endfunction

    function automatic logic [31:0] align_model(logic [31:0] d, logic [1:0] a, logic [2:0] op);
        logic [31:0] s;
        case (op[1:0])
            LD_B: begin
                s = d >> {a, 3'b000};
                return op[2] ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            end
            LD_H: begin
                s = a[1] ? d >> 16 : d;
                return op[2] ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            end
            default: return d;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", io.ms_to_ws_valid); end
        n_tests++;
        if (io.ms_fwd_bus !== '0) begin n_fail++; $display("FAIL reset_fwd: got %h want 0", io.ms_fwd_bus); end
        n_tests++;
        if (io.ms_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b want 1", io.ms_allowin); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_alu;
        io.ws_allowin     = 1'b1;
        io.es_to_ms_valid = 1'b1;
        io.es_to_ms_bus   = mk(3'b000, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000);
        exp_q.push_back({1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000});
        tick;
        io.es_to_ms_valid = 1'b0;
        settle;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b want 1", io.ms_to_ws_valid); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL alu_bus: got %h want <queue empty>", io.ms_to_ws_bus); end
        else begin
            exp_w = exp_q.pop_front();
            if (io.ms_to_ws_bus !== exp_w) begin n_fail++; $display("FAIL alu_bus: got %h want %h", io.ms_to_ws_bus, exp_w); end
        end
        n_tests++;
        if (io.ms_fwd_bus !== {1'b1, 1'b0, 5'd5, 32'h1234_5678}) begin
            n_fail++; $display("FAIL alu_fwd: got %h want %h", io.ms_fwd_bus, {1'b1, 1'b0, 5'd5, 32'h1234_5678});
        end
        tick;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drain: got %b want 0", io.ms_to_ws_valid); end
    endtask

    task automatic test_load_byte;
        io.es_to_ms_valid = 1'b1;
        io.es_to_ms_bus   = mk(3'b000, 1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'h1c00_0010);
        exp_q.push_back({1'b1, 5'd7, 32'hFFFF_FF80, 32'h1c00_0010});
        tick;
        io.es_to_ms_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle;
            n_tests++;
            if (io.ms_fwd_bus[38:37] !== 2'b11) begin n_fail++; $display("FAIL lb_block%0d: got fwd/blk %b want 11", i, io.ms_fwd_bus[38:37]); end
            n_tests++;
            if (io.ms_to_ws_valid !== 1'b0 || io.ms_allowin !== 1'b0) begin
                n_fail++; $display("FAIL lb_wait%0d: got valid/allowin %b%b want 00", i, io.ms_to_ws_valid, io.ms_allowin);
            end
            if (i == 0) tick;
        end
        tick;
        io.data_sram_data_ok = 1'b1;
        io.data_sram_rdata   = 32'h80FF_0000;
        settle;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL lb_valid: got %b want 1", io.ms_to_ws_valid); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL lb_bus: got %h want <queue empty>", io.ms_to_ws_bus); end
        else begin
            exp_w = exp_q.pop_front();
            if (io.ms_to_ws_bus !== exp_w) begin n_fail++; $display("FAIL lb_bus: got %h want %h", io.ms_to_ws_bus, exp_w); end
        end
        n_tests++;
        if (io.ms_fwd_bus !== {1'b1, 1'b0, 5'd7, 32'hFFFF_FF80}) begin
            n_fail++; $display("FAIL lb_fwd: got %h want %h", io.ms_fwd_bus, {1'b1, 1'b0, 5'd7, 32'hFFFF_FF80});
        end
        tick;
        io.data_sram_data_ok = 1'b0;
        settle;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL lb_drain: got %b want 0", io.ms_to_ws_valid); end
    endtask

    task automatic test_load_half_u;
        io.es_to_ms_valid = 1'b1;
        io.es_to_ms_bus   = mk(3'b101, 1'b1, 1'b1, 5'd9, 32'h0000_2002, 32'h1c00_0020);
        exp_q.push_back({1'b1, 5'd9, 32'h0000_8001, 32'h1c00_0020});
        tick;
        io.es_to_ms_valid    = 1'b0;
        io.data_sram_data_ok = 1'b1;
        io.data_sram_rdata   = 32'h8001_1234;
        settle;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b1 || io.ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL lhu_nostall: got valid/allowin %b%b want 11", io.ms_to_ws_valid, io.ms_allowin);
        end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL lhu_bus: got %h want <queue empty>", io.ms_to_ws_bus); end
        else begin
            exp_w = exp_q.pop_front();
            if (io.ms_to_ws_bus !== exp_w) begin n_fail++; $display("FAIL lhu_bus: got %h want %h", io.ms_to_ws_bus, exp_w); end
        end
        tick;
        io.data_sram_data_ok = 1'b0;
    endtask

    task automatic test_load_stall;
        io.ws_allowin     = 1'b1;
        io.es_to_ms_valid = 1'b1;
        io.es_to_ms_bus   = mk(3'b010, 1'b1, 1'b1, 5'd11, 32'h2000_0008, 32'h1c00_0030);
        exp_q.push_back({1'b1, 5'd11, 32'hDEAD_BEEF, 32'h1c00_0030});
        tick;
        io.es_to_ms_valid    = 1'b0;
        io.ws_allowin        = 1'b0;
        io.data_sram_data_ok = 1'b1;
        io.data_sram_rdata   = 32'hDEAD_BEEF;
        settle;
        n_tests++;
        if (io.ms_allowin !== 1'b0 || io.ms_to_ws_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_c0: got allowin/valid %b%b want 01", io.ms_allowin, io.ms_to_ws_valid);
        end
        tick;
        io.data_sram_rdata = 32'h0BAD_F00D;
        settle;
        n_tests++;
        if (dut.buf_r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_buf: got %h want deadbeef", dut.buf_r); end
        tick;
        io.data_sram_data_ok = 1'b0;
        settle;
        n_tests++;
        if (io.ms_allowin !== 1'b0 || io.ms_to_ws_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_c2: got allowin/valid %b%b want 01", io.ms_allowin, io.ms_to_ws_valid);
        end
        n_tests++;
        if (dut.buf_r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_buf2: got %h want deadbeef", dut.buf_r); end
        io.ws_allowin = 1'b1;
        settle;
        n_tests++;
        if (io.ms_allowin !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", io.ms_allowin); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stall_bus: got %h want <queue empty>", io.ms_to_ws_bus); end
        else begin
            exp_w = exp_q.pop_front();
            if (io.ms_to_ws_bus !== exp_w) begin n_fail++; $display("FAIL stall_bus: got %h want %h", io.ms_to_ws_bus, exp_w); end
        end
        tick;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", io.ms_to_ws_valid); end
    endtask

    task automatic test_back_to_back;
        logic prev_we;
        logic [31:0] alu;
        io.ws_allowin        = 1'b1;
        io.data_sram_data_ok = 1'b1;
        prev_we = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            io.data_sram_rdata = $urandom;
            io.es_to_ms_valid  = i < 4;
            if (i < 4) begin
                alu = $urandom;
                io.es_to_ms_bus = mk(3'b000, 1'b0, i[0], 5'(i + 1), alu, 32'h100 + 32'(4 * i));
            end
            settle;
            n_tests++;
            if (io.ms_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allowin%0d: got %b want 1", i, io.ms_allowin); end
            if (i > 0) begin
                n_tests++;
                if (io.ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", i, io.ms_to_ws_valid); end
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_bus%0d: got %h want <queue empty>", i, io.ms_to_ws_bus); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (io.ms_to_ws_bus !== exp_w) begin n_fail++; $display("FAIL b2b_bus%0d: got %h want %h", i, io.ms_to_ws_bus, exp_w); end
                end
                n_tests++;
                if (io.ms_fwd_bus[38] !== prev_we) begin n_fail++; $display("FAIL b2b_fwd%0d: got %b want %b", i, io.ms_fwd_bus[38], prev_we); end
            end
            if (i < 4) begin
                exp_q.push_back({i[0], 5'(i + 1), alu, 32'h100 + 32'(4 * i)});
                prev_we = i[0];
            end
            tick;
        end
        io.data_sram_data_ok = 1'b0;
        settle;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", io.ms_to_ws_valid); end
        n_tests++;
        if (dut.buf_r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_buf: got %h want deadbeef", dut.buf_r); end
    endtask

    task automatic test_align_table;
        logic [2:0]  ops[6]   = '{3'b001, 3'b100, 3'b000, 3'b011, 3'b001, 3'b110};
        logic [1:0]  addrs[6] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
        logic [31:0] datas[6] = '{32'h1234_8765, 32'h0000_AB00, 32'h5555_557F,
                                  32'hCAFE_F00D, 32'hF123_4567, 32'h89AB_CDEF};
        io.ws_allowin = 1'b1;
        for (int i = 0; i < 6; i++) begin
            io.es_to_ms_valid = 1'b1;
            io.es_to_ms_bus   = mk(ops[i], 1'b1, 1'b1, 5'd20, {30'h100, addrs[i]}, 32'h200 + 32'(i));
            exp_q.push_back({1'b1, 5'd20, align_model(datas[i], addrs[i], ops[i]), 32'h200 + 32'(i)});
            tick;
            io.es_to_ms_valid    = 1'b0;
            io.data_sram_data_ok = 1'b1;
            io.data_sram_rdata   = datas[i];
            settle;
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL align%0d: got %h want <queue empty>", i, io.ms_to_ws_bus); end
            else begin
                exp_w = exp_q.pop_front();
                if (io.ms_to_ws_valid !== 1'b1 || io.ms_to_ws_bus !== exp_w) begin
                    n_fail++; $display("FAIL align%0d: got %b/%h want 1/%h", i, io.ms_to_ws_valid, io.ms_to_ws_bus, exp_w);
                end
            end
            tick;
            io.data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_reset_mid_load;
        io.ws_allowin     = 1'b1;
        io.es_to_ms_valid = 1'b1;
        io.es_to_ms_bus   = mk(3'b010, 1'b1, 1'b1, 5'd3, 32'h3000_0000, 32'h1c00_0040);
        tick;
        io.es_to_ms_valid = 1'b0;
        settle;
        n_tests++;
        if (io.ms_fwd_bus[37] !== 1'b1) begin n_fail++; $display("FAIL rml_block: got %b want 1", io.ms_fwd_bus[37]); end
        reset = 1'b0;
        tick;
        reset                = 1'b1;
        io.data_sram_data_ok = 1'b1;
        io.data_sram_rdata   = 32'h7777_7777;
        settle;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL rml_valid: got %b want 0", io.ms_to_ws_valid); end
        n_tests++;
        if (io.ms_fwd_bus !== '0) begin n_fail++; $display("FAIL rml_fwd: got %h want 0", io.ms_fwd_bus); end
        n_tests++;
        if (io.ms_allowin !== 1'b1) begin n_fail++; $display("FAIL rml_allowin: got %b want 1", io.ms_allowin); end
        tick;
        n_tests++;
        if (io.ms_to_ws_valid !== 1'b0 || io.ms_fwd_bus !== '0) begin
            n_fail++; $display("FAIL rml_after: got %b/%h want 0/0", io.ms_to_ws_valid, io.ms_fwd_bus);
        end
        io.data_sram_data_ok = 1'b0;
    endtask

    initial begin
        io.ws_allowin        = 1'b1;
        io.es_to_ms_valid    = 1'b0;
        io.es_to_ms_bus      = '0;
        io.data_sram_data_ok = 1'b0;
        io.data_sram_rdata   = '0;
        test_reset;
        test_alu;
        test_load_byte;
        test_load_half_u;
        test_load_stall;
        test_back_to_back;
        test_align_table;
        test_reset_mid_load;
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover: got %0d pending want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline stage directly downstream of the execute stage and upstream of write-back. Accepts the execute-to-memory bus, waits for the data SRAM read response on loads, and aligns and extends the returned word for byte, halfword and word loads. Holds the result until write-back accepts it. Publishes a forward/block bus so decode can bypass results or stall on them.

Parameters:
none (all bus widths come from the shared header macros below)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
ws_allowin  in  1  write-back can accept this cycle
ms_allowin  out  1  stage can accept from execute
es_to_ms_valid  in  1  execute output valid
es_to_ms_bus  in  74  {ld_op[2:0] 73:71, res_from_mem 70, gr_we 69, dest 68:64, alu_result 63:32, pc 31:0}
ms_to_ws_valid  out  1  result valid toward write-back
ms_to_ws_bus  out  70  {gr_we 69, dest 68:64, final_result 63:32, pc 31:0}
ms_fwd_bus  out  39  {fwd_valid 38, blk_valid 37, dest 36:32, fwd_result 31:0}
data_sram_data_ok  in  1  read data returned this cycle
data_sram_rdata  in  32  read data, valid only with data_ok

Behaviour:
- Reset (reset==0 at a clock edge): state=EMPTY, buffer cleared. Outputs in reset: ms_to_ws_valid=0, ms_fwd_bus=0, ms_allowin=1. Bus register content is don't-care.
- ld_op encoding: [1:0] size (00 byte, 01 half, 10 word, 11 reserved, treated as word); [2] unsigned (zero-extend).
- States:
  - EMPTY: no instruction held.
  - WAIT: load held, data not yet returned.
  - READY: result available.
- Accept rule: when es_to_ms_valid && ms_allowin, latch the bus. Next state is WAIT if res_from_mem, else READY.
- ms_ready_go = (state==READY) || (state==WAIT && data_sram_data_ok).
- ms_allowin = (state==EMPTY) || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_ready_go.
- WAIT with data_ok:
  - If ws_allowin: rdata passes straight through the aligner, with 0 extra cycles.
  - Otherwise: capture rdata into a 32-bit buffer and move to READY.
- READY with ws_allowin: go to EMPTY, unless a new accept happens in the same cycle, in which case take the new instruction's state (back-to-back, no bubble).
- data_ok while state != WAIT is ignored and must not corrupt the buffer.
- Alignment uses addr = alu_result[1:0]:
  - byte: selects rdata[8*addr+7 : 8*addr].
  - half: uses addr[1] to select the upper or lower half; addr[0] is ignored.
  - word: all 32 bits.
  - Sign-extend unless unsigned.
- final_result = aligned load data if res_from_mem, else alu_result.
- Forward bus:
  - fwd_valid = (state!=EMPTY) && gr_we.
  - blk_valid = (state==WAIT) && !data_ok. Decode stalls on this.
  - fwd_result = final_result whenever ready_go.
- Throughput is 1 instruction/cycle for non-loads. Load latency is the SRAM latency; minimum 0 extra cycles if data_ok arrives in the first WAIT cycle.
- Reset mid-load: state returns to EMPTY. Any later data_ok is ignored.

Decomposition:
- Shared header mycpu.h gains:
  - ES_TO_MS_BUS_WD=74, MS_TO_WS_BUS_WD=70, MS_FWD_BUS_WD=39.
  - LD_B/LD_H/LD_W size codes and the state encodings EMPTY=2'd0, WAIT=2'd1, READY=2'd2.
- One natural sub-module, load_align: purely combinational (rdata, addr[1:0], ld_op) -> 32-bit extended value. It is unit-testable in isolation.

Test Plan:
- ALU op, alu_result=0x1234_5678, gr_we=1, dest=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234_5678, fwd_valid=1, blk_valid=0.
- Signed byte load at addr low bits 2'b11, data_ok after 2 cycles with rdata=0x80FF_0000 -> blk_valid=1 for those 2 cycles, then final_result=0xFFFF_FF80.
- Unsigned halfword at addr 2'b10, rdata=0x8001_1234, data_ok on first WAIT cycle -> final_result=0x0000_8001 in the same cycle, with no extra stall.
- Load with data_ok arriving while ws_allowin=0 for 3 cycles, rdata=0xDEAD_BEEF -> buffer holds 0xDEAD_BEEF; ms_allowin=0 throughout; word result delivered when ws_allowin rises.
- Four back-to-back ALU ops with ws_allowin=1 -> four consecutive valid outputs with no bubble; a spurious data_ok in READY does not change final_result.
- reset=0 asserted while in WAIT, then data_ok=1 -> state EMPTY, ms_to_ws_valid=0, ms_fwd_bus=0.
